// File: rtl/sap_controller.sv
// SAP-1 style controller-sequencer: a six-step ring counter (T1..T6) that
// decodes the instruction-register opcode into the datapath load/enable strobes.
module sap_controller #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       hlt,
  output logic [5:0] t_state
);

  // One-hot encoding: the low six bits are the ring counter itself, bit 6 is HALT.
  typedef enum logic [6:0] {
    S_T1   = 7'b000_0001,
    S_T2   = 7'b000_0010,
    S_T3   = 7'b000_0100,
    S_T4   = 7'b000_1000,
    S_T5   = 7'b001_0000,
    S_T6   = 7'b010_0000,
    S_HALT = 7'b100_0000
  } state_t;

  state_t r_state;
  state_t w_state_next;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_T1;
    end else begin
      r_state <= w_state_next;
    end
  end

  // HLT is decoded in T4 (first cycle with a valid opcode) and leaves the ring.
  always_comb begin
    w_state_next = S_T1;
    case (r_state)
      S_T1:    w_state_next = S_T2;
      S_T2:    w_state_next = S_T3;
      S_T3:    w_state_next = S_T4;
      S_T4:    w_state_next = (opcode == OP_HLT) ? S_HALT : S_T5;
      S_T5:    w_state_next = S_T6;
      S_T6:    w_state_next = S_T1;
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_T1;
    endcase
  end

  always_comb begin
    cp = 1'b0;
    ep = 1'b0;
    lm = 1'b0;
    ce = 1'b0;
    li = 1'b0;
    ei = 1'b0;
    la = 1'b0;
    ea = 1'b0;
    su = 1'b0;
    eu = 1'b0;
    lb = 1'b0;
    lo = 1'b0;
    if (!clr) begin
      case (r_state)
        S_T1: begin
          ep = 1'b1;
          lm = 1'b1;
        end
        S_T2: cp = 1'b1;
        S_T3: begin
          ce = 1'b1;
          li = 1'b1;
        end
        S_T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ei = 1'b1;
            lm = 1'b1;
          end else if (opcode == OP_OUT) begin
            ea = 1'b1;
            lo = 1'b1;
          end
        end
        S_T5: begin
          if (opcode == OP_LDA) begin
            ce = 1'b1;
            la = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ce = 1'b1;
            lb = 1'b1;
          end
        end
        S_T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            eu = 1'b1;
            la = 1'b1;
            su = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign t_state = r_state[5:0];
  assign hlt     = r_state[6];

endmodule

// File: tb/tb_sap_controller.sv
// Self-checking bench for sap_controller: a step/halt reference model predicts
// every output each cycle under directed and randomized opcode/reset stimulus.
module tb_sap_controller;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
  logic [5:0] t_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: instruction step 1..6 plus a halted flag.
  int   m_step = 1;
  logic m_halt = 1'b0;

  localparam int CP = 11, EP = 10, LM = 9, CE = 8, LI = 7, EI = 6;
  localparam int LA = 5, EA = 4, SU = 3, EU = 2, LB = 1, LO = 0;

  logic [11:0] obs_ctrl;
  logic [18:0] obs_all;
  logic [18:0] exp_all;

  assign obs_ctrl = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
  assign obs_all  = {hlt, t_state, obs_ctrl};

  sap_controller dut (
    .clk(clk), .clr(clr), .opcode(opcode),
    .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la),
    .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo), .hlt(hlt), .t_state(t_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected strobes written straight from the instruction table.
  function automatic logic [11:0] exp_ctrl(int step, logic [3:0] op, logic halt, logic rst);
    logic [11:0] c;
    c = '0;
    if (rst || halt) return c;
    case (step)
      1: begin c[EP] = 1'b1; c[LM] = 1'b1; end
      2: c[CP] = 1'b1;
      3: begin c[CE] = 1'b1; c[LI] = 1'b1; end
      4: begin
        if (op <= 4'h2) begin c[EI] = 1'b1; c[LM] = 1'b1; end
        else if (op == 4'hE) begin c[EA] = 1'b1; c[LO] = 1'b1; end
      end
      5: begin
        if (op == 4'h0) begin c[CE] = 1'b1; c[LA] = 1'b1; end
        else if (op == 4'h1 || op == 4'h2) begin c[CE] = 1'b1; c[LB] = 1'b1; end
      end
      6: begin
        if (op == 4'h1 || op == 4'h2) begin c[EU] = 1'b1; c[LA] = 1'b1; c[SU] = (op == 4'h2); end
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [18:0] model_out();
    logic [5:0] ts;
    ts = m_halt ? 6'd0 : 6'(1 << (m_step - 1));
    return {m_halt, ts, exp_ctrl(m_step, opcode, m_halt, clr)};
  endfunction

  // Advance one clock and the model with it; inputs are then stable until the next call.
  task automatic tick();
    @(posedge clk);
    if (clr) begin
      m_step = 1;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_step == 4 && opcode == 4'hF) m_halt = 1'b1;
      else m_step = (m_step == 6) ? 1 : m_step + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    exp_all = {1'b0, 6'b000001, 12'h000};
    n_cmp++;
    if (obs_all !== exp_all) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=%h", obs_all, exp_all);
    end
    for (int r = 0; r < 4; r++) begin
      clr = 1'b0;
      for (int k = 0; k < int'($urandom_range(1, 15)); k++) begin
        opcode = 4'($urandom);
        tick();
      end
      clr = 1'b1;
      opcode = 4'($urandom);
      #1;
      n_cmp++;
      if (obs_ctrl !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_strobes_forced got=%h want=000", obs_ctrl);
      end
      tick();
      clr = 1'b0;
      #1;
      n_cmp++;
      if (obs_all !== {1'b0, 6'b000001, 12'h600}) begin
        n_fail++;
        $display("FAIL reset_to_t1 got=%h want=%h", obs_all, {1'b0, 6'b000001, 12'h600});
      end
      $display("reset pass %0d: back to T1", r);
    end
  endtask

  task automatic test_fetch_execute();
    logic [3:0] ops[5] = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h7};
    for (int i = 0; i < 15; i++) begin
      opcode = (i < 5) ? ops[i] : ops[$urandom_range(0, 4)];
      for (int s = 0; s < 6; s++) begin
        #1;
        exp_all = model_out();
        n_cmp++;
        if (obs_all !== exp_all) begin
          n_fail++;
          $display("FAIL exec op=%h step=%0d got=%h want=%h", opcode, m_step, obs_all, exp_all);
        end
        tick();
      end
      n_cmp++;
      if (t_state !== 6'b000001) begin
        n_fail++;
        $display("FAIL exec_wrap op=%h got=%b want=000001", opcode, t_state);
      end
      $display("instr op=%h complete, t_state=%b", opcode, t_state);
    end
  endtask

  task automatic test_halt();
    opcode = 4'hF;
    for (int s = 0; s < 4; s++) begin
      #1;
      exp_all = model_out();
      n_cmp++;
      if (obs_all !== exp_all) begin
        n_fail++;
        $display("FAIL hlt_fetch step=%0d got=%h want=%h", m_step, obs_all, exp_all);
      end
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (obs_all !== {1'b1, 6'b000000, 12'h000}) begin
        n_fail++;
        $display("FAIL halted cyc=%0d got=%h want=%h", c, obs_all, {1'b1, 6'b000000, 12'h000});
      end
      opcode = 4'($urandom);
      tick();
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    n_cmp++;
    if (obs_all !== {1'b0, 6'b000001, 12'h600}) begin
      n_fail++;
      $display("FAIL halt_exit got=%h want=%h", obs_all, {1'b0, 6'b000001, 12'h600});
    end
    $display("halt held 20 cycles, cleared to T1");
  endtask

  task automatic test_reset_mid_add();
    opcode = 4'h1;
    for (int s = 0; s < 4; s++) tick();
    clr = 1'b1;
    #1;
    n_cmp++;
    if (lb !== 1'b0 || t_state !== 6'b010000) begin
      n_fail++;
      $display("FAIL mid_add_clr lb=%b t_state=%b want lb=0 t_state=010000", lb, t_state);
    end
    tick();
    clr = 1'b0;
    opcode = 4'h0;
    for (int s = 0; s < 6; s++) begin
      #1;
      exp_all = model_out();
      n_cmp++;
      if (obs_all !== exp_all || lb !== 1'b0) begin
        n_fail++;
        $display("FAIL after_mid_reset step=%0d got=%h want=%h", m_step, obs_all, exp_all);
      end
      tick();
    end
    $display("reset in ADD T5 restarted at T1 with no lb");
  endtask

  task automatic test_program();
    logic [3:0] prog[5] = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF};
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      opcode = prog[i];
      for (int s = 0; s < 6; s++) begin
        #1;
        exp_all = model_out();
        n_cmp++;
        if (obs_all !== exp_all) begin
          n_fail++;
          $display("FAIL prog op=%h step=%0d got=%h want=%h", opcode, m_step, obs_all, exp_all);
        end
        n_cmp++;
        if ($countones({ep, ce, ei, ea, eu}) > 1 || (cp && (ce || ei || ea || eu)) ||
            (hlt ? (t_state != 6'd0) : ($countones(t_state) != 1))) begin
          n_fail++;
          $display("FAIL prog_invariant op=%h drivers=%b cp=%b t_state=%b hlt=%b",
                   opcode, {ep, ce, ei, ea, eu}, cp, t_state, hlt);
        end
        tick();
      end
      $display("program instr %0d op=%h hlt=%b t_state=%b", i, opcode, hlt, t_state);
    end
  endtask

  task automatic test_random();
    clr = 1'b1;
    tick();
    for (int c = 0; c < 400; c++) begin
      clr = ($urandom_range(0, 39) == 0);
      opcode = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
      #1;
      exp_all = model_out();
      n_cmp++;
      if (obs_all !== exp_all) begin
        n_fail++;
        $display("FAIL random cyc=%0d clr=%b op=%h got=%h want=%h", c, clr, opcode, obs_all, exp_all);
      end
      tick();
    end
    $display("random run: 400 cycles");
  endtask

  initial begin
    test_reset();
    test_fetch_execute();
    test_halt();
    test_reset_mid_add();
    test_program();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_controller.md
Name: sap_controller

Overview:
- Controller-sequencer for the 8-bit bus datapath: PC, MAR, RAM, instruction register, A/B registers, adder/subtractor, output register.
- Runs a one-hot 6-state ring counter (T1..T6).
- Takes the 4-bit opcode from the instruction register's upper nibble (ir ctrl output).
- Drives every load/enable strobe of the datapath as active-high control signals. Stops the machine on HLT.

Parameters:
- OP_LDA, 4'h0, opcode for load accumulator from memory
- OP_ADD, 4'h1, opcode for A <= A + mem
- OP_SUB, 4'h2, opcode for A <= A - mem
- OP_OUT, 4'hE, opcode for output register <= A
- OP_HLT, 4'hF, opcode for halt

Ports:
- clk  input  1  system clock; all state changes on rising edge
- clr  input  1  synchronous active-high reset
- opcode  input  4  instruction register upper nibble (ir ctrl); valid from T4 onward
- cp  output  1  PC increment
- ep  output  1  PC drives bus
- lm  output  1  MAR load from bus
- ce  output  1  RAM drives bus
- li  output  1  instruction register load from bus
- ei  output  1  instruction register drives bus (operand nibble)
- la  output  1  A register load from bus
- ea  output  1  A register drives bus
- su  output  1  ALU subtract select (0=add)
- eu  output  1  ALU drives bus
- lb  output  1  B register load from bus
- lo  output  1  output register load from bus
- hlt  output  1  machine halted
- t_state  output  6  one-hot ring counter, bit0=T1 .. bit5=T6

Behaviour:
- Reset (clr=1 at rising edge):
  - next state is T1 (t_state=6'b000001), hlt=0.
  - Valid from any state, including HALT and mid-instruction.
  - While clr=1, all control outputs are forced to 0 combinationally.
- Ring counter:
  - advances T1->T2->...->T6->T1 on each rising edge when clr=0 and not halted.
  - Exactly one t_state bit is set at all times outside HALT.
  - In HALT, t_state=0.
- Control outputs:
  - Combinational from current state and opcode (Moore on state, opcode-qualified in T4-T6).
  - All signals not listed for a state are 0.
- Fetch (opcode-independent):
  - T1: ep, lm.
  - T2: cp.
  - T3: ce, li. The instruction register latches at the end of T3; opcode is treated as valid from T4.
- Execute:
  - LDA: T4 ei, lm; T5 ce, la; T6 none.
  - ADD: T4 ei, lm; T5 ce, lb; T6 eu, la (su=0).
  - SUB: T4 ei, lm; T5 ce, lb; T6 eu, la, su. su is asserted only in T6.
  - OUT: T4 ea, lo; T5, T6 none.
  - HLT: T4 asserts no strobes. At the T4 rising edge the FSM enters HALT instead of T5.
  - Undefined opcodes: T4-T6 all strobes 0 (NOP); sequencing continues normally.
- HALT:
  - hlt=1, all strobes 0, t_state=0.
  - Opcode changes are ignored.
  - Only clr exits HALT (to T1).
- Instruction length:
  - Every non-HLT instruction takes exactly 6 cycles.
  - The first fetch after reset starts in the cycle following the reset edge.
- Bus-contention invariants, in every state:
  - At most one of {ep, ce, ei, ea, eu} is 1.
  - cp never coincides with any bus driver except ep=0.
- su must be 0 in every state except SUB T6.

Test Plan:
- Reset: clr=1 for one edge from arbitrary state → t_state=6'b000001, hlt=0. While clr=1, all strobes=0.
- Fetch: clr released, opcode=4'h0 → T1: ep=lm=1; T2: cp=1; T3: ce=li=1; all others 0; t_state walks 01,02,04.
- LDA/ADD/SUB execute, with opcode=4'h0/4'h1/4'h2 held:
  - T4: ei=lm=1 for all three.
  - T5: ce=la=1 (LDA) / ce=lb=1 (ADD, SUB).
  - T6: none (LDA) / eu=la=1, su=0 (ADD) / eu=la=su=1 (SUB).
  - Next edge returns to T1 (t_state=6'b000001).
- OUT, then undefined opcode:
  - opcode=4'hE → T4: ea=lo=1; T5/T6 all 0.
  - opcode=4'h7 → T4-T6 all 0, counter still wraps to T1.
- HLT and reset mid-operation:
  - opcode=4'hF → after the T4 edge, hlt=1, t_state=0; stays halted for 20 cycles despite opcode toggling.
  - clr=1 one edge → T1, hlt=0.
  - Separately, clr asserted in T5 of ADD → next state T1; lb never asserted after reset.
- Invariant check across a 5-instruction program (LDA, ADD, SUB, OUT, HLT): every cycle has ≤1 bus driver active and exactly one t_state bit set (or zero when hlt=1).
